displayer: RTL and testbench



---
 rtl/disp_pkg.sv | 60 ++++++
 rtl/displayer.sv | 37 +++
 tb/tb_displayer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared seven-segment constants and the active-high digit decoder.
// Segment bit order is {a,b,c,d,e,f,g}: bit 6 is the top bar, bit 0 the middle bar.
// The hour/minute display decoders also import this package for their
// blank and zero constants.
package disp_pkg;

    localparam int SEG_WIDTH   = 7;
    localparam int DIGIT_WIDTH = 4;

    // Decimal glyphs, active-high (a lit segment is 1)
    localparam logic [SEG_WIDTH-1:0] SEG_0 = 7'h7E;
    localparam logic [SEG_WIDTH-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_WIDTH-1:0] SEG_2 = 7'h6D;
    localparam logic [SEG_WIDTH-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_WIDTH-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_WIDTH-1:0] SEG_5 = 7'h5B;
    localparam logic [SEG_WIDTH-1:0] SEG_6 = 7'h5F;
    localparam logic [SEG_WIDTH-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_WIDTH-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_WIDTH-1:0] SEG_9 = 7'h7B;

    // Hex glyphs A, b, C, d, E, F, active-high
    localparam logic [SEG_WIDTH-1:0] SEG_A = 7'h77;
    localparam logic [SEG_WIDTH-1:0] SEG_B = 7'h1F;
    localparam logic [SEG_WIDTH-1:0] SEG_C = 7'h4E;
    localparam logic [SEG_WIDTH-1:0] SEG_D = 7'h3D;
    localparam logic [SEG_WIDTH-1:0] SEG_E = 7'h4F;
    localparam logic [SEG_WIDTH-1:0] SEG_F = 7'h47;

    // All segments dark
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h00;

    // Active-high pattern for one digit value. Values 10-15 show a hex glyph
    // only when hex_en is set, otherwise the digit is blanked. The default
    // arm keeps X off the segments even if v is unknown.
    function automatic logic [SEG_WIDTH-1:0] seg_decode(logic [DIGIT_WIDTH-1:0] v, bit hex_en);
        logic [SEG_WIDTH-1:0] p;
        case (v)
            4'h0:    p = SEG_0;
            4'h1:    p = SEG_1;
            4'h2:    p = SEG_2;
            4'h3:    p = SEG_3;
            4'h4:    p = SEG_4;
            4'h5:    p = SEG_5;
            4'h6:    p = SEG_6;
            4'h7:    p = SEG_7;
            4'h8:    p = SEG_8;
            4'h9:    p = SEG_9;
            4'hA:    p = hex_en ? SEG_A : SEG_BLANK;
            4'hB:    p = hex_en ? SEG_B : SEG_BLANK;
            4'hC:    p = hex_en ? SEG_C : SEG_BLANK;
            4'hD:    p = hex_en ? SEG_D : SEG_BLANK;
            4'hE:    p = hex_en ? SEG_E : SEG_BLANK;
            4'hF:    p = hex_en ? SEG_F : SEG_BLANK;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/displayer.sv
// Registered single-digit seven-segment decoder. The decode is combinational
// and the result is captured in one output register, so every digit in a
// multi-digit display changes on the same clock edge.
module displayer
    import disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit HEX_EN     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGIT_WIDTH-1:0] digit,
    output logic [SEG_WIDTH-1:0]   seg
);

    // Blank as seen on the pins, i.e. after the polarity is applied
    localparam logic [SEG_WIDTH-1:0] BLANK_LEVEL = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [SEG_WIDTH-1:0] decoded;
    logic [SEG_WIDTH-1:0] driven;

    // Decode the digit, then flip every bit when the display is wired active-low
    always_comb begin
        decoded = seg_decode(digit, HEX_EN);
        driven  = ACTIVE_LOW ? ~decoded : decoded;
    end

    // Output register: reset blanks the digit, otherwise load the new pattern
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= BLANK_LEVEL;
        end else begin
            seg <= driven;
        end
    end

endmodule

// File: tb/tb_displayer.sv
// Self-checking bench for displayer: a fixed vector table, hand-written
// sequences for reset timing and the six-digit bank, and a randomized run
// compared against a reference model built from lit-segment letter lists.
module tb_displayer;

    logic       clk;
    logic       rstN;
    logic [3:0] digit;
    logic [6:0] segDef;
    logic [6:0] segHex;
    logic [6:0] segLow;
    logic [6:0] segLowHex;
    logic [3:0] bankDigit [6];
    logic [6:0] bankSeg   [6];

    int errors;
    int checks;

    typedef struct {
        logic       rstN;
        logic [3:0] digit;
        logic [6:0] expDef;
        logic [6:0] expHex;
    } vec_t;

    vec_t vecs[$];

    displayer #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dutDef (
        .clk(clk), .rst_n(rstN), .digit(digit), .seg(segDef));
    displayer #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dutHex (
        .clk(clk), .rst_n(rstN), .digit(digit), .seg(segHex));
    displayer #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) dutLow (
        .clk(clk), .rst_n(rstN), .digit(digit), .seg(segLow));
    displayer #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dutLowHex (
        .clk(clk), .rst_n(rstN), .digit(digit), .seg(segLowHex));

    for (genvar g = 0; g < 6; g++) begin : gBank
        displayer dutBank (
            .clk(clk), .rst_n(rstN), .digit(bankDigit[g]), .seg(bankSeg[g]));
    end

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Which segments a glyph lights, as letters a..g
    function automatic string litSegments(int v);
        case (v)
            0:  return "abcdef";
            1:  return "bc";
            2:  return "abdeg";
            3:  return "abcdg";
            4:  return "bcfg";
            5:  return "acdfg";
            6:  return "acdefg";
            7:  return "abc";
            8:  return "abcdefg";
            9:  return "abcdfg";
            10: return "abcefg";
            11: return "cdefg";
            12: return "adef";
            13: return "bcdeg";
            14: return "adefg";
            15: return "aefg";
            default: return "";
        endcase
    endfunction

    // Reference: pin value expected after an edge, given that edge's inputs
    function automatic logic [6:0] modelSeg(bit inReset, int v, bit hexEn, bit activeLow);
        string lit;
        logic [6:0] p;
        p = 7'h00;
        lit = "";
        if (!inReset && (v < 10 || hexEn)) lit = litSegments(v);
        for (int i = 0; i < lit.len(); i++) begin
            p[6 - (int'(lit[i]) - 97)] = 1'b1;
        end
        return activeLow ? ~p : p;
    endfunction

    task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs on the falling edge, then step past the next rising edge
    task automatic applyStimulus(input logic r, input logic [3:0] d);
        @(negedge clk);
        rstN  = r;
        digit = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstN   = 1'b0;
        digit  = 4'd0;
        for (int i = 0; i < 6; i++) bankDigit[i] = 4'd0;

        // Reset hold with digit 8, release, then sweep 0..15
        vecs.push_back('{1'b0, 4'd8,  7'h00, 7'h00});
        vecs.push_back('{1'b0, 4'd8,  7'h00, 7'h00});
        vecs.push_back('{1'b1, 4'd8,  7'h7F, 7'h7F});
        vecs.push_back('{1'b1, 4'd0,  7'h7E, 7'h7E});
        vecs.push_back('{1'b1, 4'd1,  7'h30, 7'h30});
        vecs.push_back('{1'b1, 4'd2,  7'h6D, 7'h6D});
        vecs.push_back('{1'b1, 4'd3,  7'h79, 7'h79});
        vecs.push_back('{1'b1, 4'd4,  7'h33, 7'h33});
        vecs.push_back('{1'b1, 4'd5,  7'h5B, 7'h5B});
        vecs.push_back('{1'b1, 4'd6,  7'h5F, 7'h5F});
        vecs.push_back('{1'b1, 4'd7,  7'h70, 7'h70});
        vecs.push_back('{1'b1, 4'd8,  7'h7F, 7'h7F});
        vecs.push_back('{1'b1, 4'd9,  7'h7B, 7'h7B});
        vecs.push_back('{1'b1, 4'd10, 7'h00, 7'h77});
        vecs.push_back('{1'b1, 4'd11, 7'h00, 7'h1F});
        vecs.push_back('{1'b1, 4'd12, 7'h00, 7'h4E});
        vecs.push_back('{1'b1, 4'd13, 7'h00, 7'h3D});
        vecs.push_back('{1'b1, 4'd14, 7'h00, 7'h4F});
        vecs.push_back('{1'b1, 4'd15, 7'h00, 7'h47});

        // Table: active-low instances must show the exact inverse
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].digit);
            checkOutput($sformatf("vec%0d_def", i),    segDef,    vecs[i].expDef);
            checkOutput($sformatf("vec%0d_hex", i),    segHex,    vecs[i].expHex);
            checkOutput($sformatf("vec%0d_low", i),    segLow,    ~vecs[i].expDef);
            checkOutput($sformatf("vec%0d_lowhex", i), segLowHex, ~vecs[i].expHex);
        end

        // Active-low spot values written out directly
        applyStimulus(1'b0, 4'd3);
        checkOutput("low_reset", segLow, 7'h7F);
        applyStimulus(1'b1, 4'd0);
        checkOutput("low_zero", segLow, 7'h01);
        applyStimulus(1'b1, 4'd1);
        checkOutput("low_one", segLow, 7'h4F);
        applyStimulus(1'b1, 4'd12);
        checkOutput("low_twelve_blank", segLow, 7'h7F);

        // Reset on the edge that would load 5, then release with 5 still present
        applyStimulus(1'b1, 4'd3);
        checkOutput("stream_3", segDef, 7'h79);
        applyStimulus(1'b1, 4'd4);
        checkOutput("stream_4", segDef, 7'h33);
        applyStimulus(1'b0, 4'd5);
        checkOutput("stream_reset_on_5", segDef, 7'h00);
        applyStimulus(1'b1, 4'd5);
        checkOutput("stream_release_5", segDef, 7'h5B);

        // Reset between edges must not touch the register
        @(negedge clk);
        rstN = 1'b0;
        #2;
        checkOutput("no_async_reset", segDef, 7'h5B);
        checkOutput("no_async_reset_low", segLow, 7'h24);
        @(posedge clk);
        #1;
        checkOutput("sync_reset_lands", segDef, 7'h00);

        // Six-digit bank showing 23:59 plus two constant zeros
        @(negedge clk);
        rstN = 1'b1;
        bankDigit[0] = 4'd2;
        bankDigit[1] = 4'd3;
        bankDigit[2] = 4'd5;
        bankDigit[3] = 4'd9;
        bankDigit[4] = 4'd0;
        bankDigit[5] = 4'd0;
        @(posedge clk);
        #1;
        checkOutput("bank_h10", bankSeg[0], 7'h6D);
        checkOutput("bank_h1",  bankSeg[1], 7'h79);
        checkOutput("bank_m10", bankSeg[2], 7'h5B);
        checkOutput("bank_m1",  bankSeg[3], 7'h7B);
        checkOutput("bank_z0",  bankSeg[4], 7'h7E);
        checkOutput("bank_z1",  bankSeg[5], 7'h7E);

        // Randomized run against the reference model
        for (int n = 0; n < 300; n++) begin
            logic       r;
            logic [3:0] d;
            int         bd [6];
            r = ($urandom_range(0, 9) != 0);
            d = 4'($urandom_range(0, 15));
            for (int k = 0; k < 6; k++) bd[k] = int'($urandom_range(0, 15));
            @(negedge clk);
            for (int k = 0; k < 6; k++) bankDigit[k] = 4'(bd[k]);
            rstN  = r;
            digit = d;
            @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d_def", n),    segDef,    modelSeg(!r, int'(d), 1'b0, 1'b0));
            checkOutput($sformatf("rnd%0d_hex", n),    segHex,    modelSeg(!r, int'(d), 1'b1, 1'b0));
            checkOutput($sformatf("rnd%0d_low", n),    segLow,    modelSeg(!r, int'(d), 1'b0, 1'b1));
            checkOutput($sformatf("rnd%0d_lowhex", n), segLowHex, modelSeg(!r, int'(d), 1'b1, 1'b1));
            for (int k = 0; k < 6; k++) begin
                checkOutput($sformatf("rnd%0d_bank%0d", n, k), bankSeg[k], modelSeg(!r, bd[k], 1'b0, 1'b0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
